lk_list_builder: RTL and testbench
==================================

# lk_list_builder

Upstream producer for the linked-list summing FSM in the automatic reseller. It accepts inserted-coin values, allocates list nodes in the shared list RAM and writes them, and keeps the list head. On a buy request it hands the list to the summing stage through the `sum_start`/`done` handshake, then frees the whole list. Address 0 is the null pointer: a node whose next field is 0 terminates the list.

## Interface
- `ADDR_W`, 4: node address width; nodes occupy addresses 1..2^ADDR_W-1.
- `DATA_W`, 8: coin value width.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `coin_valid`  in  1  a coin value is offered; held until accepted.
- `coin_value`  in  DATA_W  value of the offered coin.
- `coin_ready`  out  1  coin is accepted at an edge where `coin_valid` & `coin_ready`.
- `buy_req`  in  1  level request to total and clear the list; held until `buy_ack` or `buy_reject`.
- `buy_ack`  out  1  one-cycle pulse: the buy was taken.
- `buy_reject`  out  1  one-cycle pulse: the buy was refused because the list is empty.
- `mem_we`  out  1  list RAM write strobe.
- `mem_waddr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W+ADDR_W  node contents, {value, next}.
- `head_addr`  out  ADDR_W  first node of the list; 0 when empty.
- `sum_start`  out  1  start/hold request to the summing FSM.
- `sum_done`  in  1  the summing FSM's `done`.
- `count`  out  ADDR_W  number of live nodes.
- `list_full`  out  1  `count` == 2^ADDR_W-1.
- `busy`  out  1  a buy is in progress (START, WAIT or CLEAR).

## Operation
- States: IDLE, WRITE, START, WAIT, CLEAR.
- Internal free pointer `free_ptr`; reset value 1.
- Reset values while `reset` is low:
  - state IDLE; `head_addr`=0, `count`=0, `free_ptr`=1.
  - `mem_we`, `sum_start`, `buy_ack`, `buy_reject`, `busy` = 0; `list_full`=0.
  - `mem_waddr`, `mem_wdata` = 0.
  - `coin_ready`=1, because it is combinational: state==IDLE & !`list_full`.
- IDLE, coin accepted:
  - Next state WRITE.
  - Registered outputs: `mem_we`=1, `mem_waddr`=`free_ptr`, `mem_wdata`={`coin_value`, `head_addr`}.
  - `head_addr`←`free_ptr`, `free_ptr`+1, `count`+1. New nodes are prepended.
- WRITE: `mem_we` drops, return to IDLE. `coin_ready`=0 here, so the maximum rate is one coin per 2 cycles.
- IDLE, `buy_req`=1 with no coin accepted at the same edge:
  - If `count`>0: go to START; `buy_ack` pulses; `sum_start`=1 and `busy`=1.
  - If `count`=0: `buy_reject` pulses and the state stays IDLE.
- Simultaneous `coin_valid` and `buy_req`: the coin wins. The buy is evaluated at the next IDLE edge.
- START: `sum_start`=1; go to WAIT the next cycle.
- WAIT: hold `sum_start`=1 until `sum_done`=1, then go to CLEAR.
- CLEAR:
  - `sum_start`=0.
  - Stay until `sum_done`=0, which is the summer returning to its idle state.
  - At that edge: `head_addr`=0, `free_ptr`=1, `count`=0, `busy`=0, go to IDLE.
- Full: `list_full`=1 forces `coin_ready`=0. An offered coin waits with no write and no state change. A buy is still legal.
- Pointer arithmetic is unsigned ADDR_W. `free_ptr` never wraps past 2^ADDR_W-1, because accept is blocked at full.
- `head_addr` and `count` are stable from START through CLEAR, so the summer may read them freely.
- Reset asserted mid-operation: all state clears immediately and `sum_start` falls asynchronously. The summing FSM is reset in the same domain.

## Timing
- Coin accepted at edge E:
  - `mem_we`=1 during the cycle E..E+1.
  - `head_addr`/`count` update at E.
  - `coin_ready` rises again after E+1.
- Buy taken at edge E:
  - `sum_start`=1 and `buy_ack`=1 after E.
  - `buy_ack` is low after E+1.
- `sum_done` high sampled at edge D: `sum_start`=0 after D.
- `sum_done` low sampled at edge F: list cleared and IDLE after F.
- No combinational path from inputs to outputs except `coin_ready` (state and `list_full` only).

## Test plan
- Reset low for 3 cycles, then release -> `head_addr`=0, `count`=0, `coin_ready`=1, `sum_start`=0, `mem_we`=0.
- Coins 5, 10, 20 back-to-back ->
  - Writes: addr1={5,0}, addr2={10,1}, addr3={20,2}.
  - `head_addr`=3, `count`=3.
  - `coin_ready` low on each cycle after an accept.
- After the 3 coins, `buy_req` with a behavioural summer that asserts `done` 6 cycles after `sum_start` ->
  - `buy_ack` pulse; `sum_start` held until `done`.
  - After `done` falls: `count`=0, `head_addr`=0, IDLE.
- 15 coins with `ADDR_W`=4 -> `list_full`=1, `coin_ready`=0. A 16th `coin_valid` held 10 cycles produces no `mem_we`.
- `buy_req` on an empty list -> one `buy_reject` pulse, no `sum_start`. With `coin_valid` and `buy_req` on the same edge -> the coin is written first, then `buy_ack` follows.
- Reset pulsed low during WAIT -> `sum_start`=0 immediately, `count`=0, and a new coin is accepted at addr1.

Source files
------------

// File: rtl/lk_list_builder_if.sv
// Handshake and status bundle between the coin-list builder and its environment
// (coin source, buy requester, list RAM write port and summing FSM).
interface lk_list_builder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic                     coin_valid;
  logic [DATA_W-1:0]        coin_value;
  logic                     coin_ready;
  logic                     buy_req;
  logic                     buy_ack;
  logic                     buy_reject;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [DATA_W+ADDR_W-1:0] mem_wdata;
  logic [ADDR_W-1:0]        head_addr;
  logic                     sum_start;
  logic                     sum_done;
  logic [ADDR_W-1:0]        count;
  logic                     list_full;
  logic                     busy;

  modport master (
    input  coin_valid, coin_value, buy_req, sum_done,
    output coin_ready, buy_ack, buy_reject, mem_we, mem_waddr, mem_wdata,
           head_addr, sum_start, count, list_full, busy
  );

  modport slave (
    output coin_valid, coin_value, buy_req, sum_done,
    input  coin_ready, buy_ack, buy_reject, mem_we, mem_waddr, mem_wdata,
           head_addr, sum_start, count, list_full, busy
  );
endinterface

// File: rtl/lk_list_builder.sv
// Builds a singly linked list of coin values in the list RAM (newest node first)
// and hands it to the summing FSM on a buy, then frees the whole list.
module lk_list_builder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  lk_list_builder_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_START,
    S_WAIT,
    S_CLEAR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] free_ptr;
  logic              coin_take;

  // Count is registered, so these carry no input-to-output path.
  assign bus.list_full  = (bus.count == {ADDR_W{1'b1}});
  assign bus.coin_ready = (state == S_IDLE) && !bus.list_full;
  assign coin_take      = bus.coin_valid && bus.coin_ready;

  // NOTE: every register here is state, so only non-blocking assignments are
  // used; the reset branch clears all of them, including sum_start, at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      free_ptr       <= ADDR_W'(1);
      bus.head_addr  <= '0;
      bus.count      <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_waddr  <= '0;
      bus.mem_wdata  <= '0;
      bus.sum_start  <= 1'b0;
      bus.buy_ack    <= 1'b0;
      bus.buy_reject <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.mem_we     <= 1'b0;
      bus.buy_ack    <= 1'b0;
      bus.buy_reject <= 1'b0;

      case (state)
        S_IDLE: begin
          if (coin_take) begin
            // Prepend: the new node points at the old head.
            bus.mem_we    <= 1'b1;
            bus.mem_waddr <= free_ptr;
            bus.mem_wdata <= {bus.coin_value, bus.head_addr};
            bus.head_addr <= free_ptr;
            free_ptr      <= free_ptr + ADDR_W'(1);
            bus.count     <= bus.count + ADDR_W'(1);
            state         <= S_WRITE;
          end else if (bus.buy_req) begin
            if (bus.count != '0) begin
              bus.buy_ack   <= 1'b1;
              bus.sum_start <= 1'b1;
              bus.busy      <= 1'b1;
              state         <= S_START;
            end else begin
              bus.buy_reject <= 1'b1;
            end
          end
        end

        S_WRITE: state <= S_IDLE;

        S_START: state <= S_WAIT;

        S_WAIT: begin
          if (bus.sum_done) begin
            bus.sum_start <= 1'b0;
            state         <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          // Wait for the summer to drop done before freeing the list.
          if (!bus.sum_done) begin
            bus.head_addr <= '0;
            bus.count     <= '0;
            free_ptr      <= ADDR_W'(1);
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lk_list_builder.sv
// Directed bench for lk_list_builder with a behavioural summing FSM that
// raises done six cycles after sum_start and drops it once sum_start falls.
module tb_lk_list_builder;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic clock;
  logic reset;

  lk_list_builder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  lk_list_builder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural summer.
  int sum_cnt;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.sum_done <= 1'b0;
      sum_cnt      <= 0;
    end else if (bus.sum_start && !bus.sum_done) begin
      if (sum_cnt == 5) bus.sum_done <= 1'b1;
      sum_cnt <= sum_cnt + 1;
    end else if (!bus.sum_start) begin
      bus.sum_done <= 1'b0;
      sum_cnt      <= 0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer a coin, wait (bounded) for coin_ready, step through the accept edge.
  task automatic send_coin(input logic [DATA_W-1:0] v);
    int guard;
    guard = 0;
    bus.coin_valid = 1'b1;
    bus.coin_value = v;
    while (!bus.coin_ready && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) check("coin_ready_timeout", 32'(guard), 0);
    step();
    bus.coin_valid = 1'b0;
  endtask

  // Step until busy falls, bounded; returns cycles taken.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) check("busy_timeout", 32'(n), 0);
  endtask

  int n;
  int we_seen;

  initial begin
    bus.coin_valid = 1'b0;
    bus.coin_value = '0;
    bus.buy_req    = 1'b0;
    reset          = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Reset state
    check("rst_head",  32'(bus.head_addr), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_ready", 32'(bus.coin_ready), 1);
    check("rst_start", 32'(bus.sum_start), 0);
    check("rst_we",    32'(bus.mem_we), 0);
    check("rst_full",  32'(bus.list_full), 0);
    check("rst_busy",  32'(bus.busy), 0);

    // Three coins, prepended
    send_coin(8'd5);
    check("c1_we",    32'(bus.mem_we), 1);
    check("c1_addr",  32'(bus.mem_waddr), 1);
    check("c1_data",  32'(bus.mem_wdata), 32'h050);
    check("c1_ready", 32'(bus.coin_ready), 0);
    send_coin(8'd10);
    check("c2_addr",  32'(bus.mem_waddr), 2);
    check("c2_data",  32'(bus.mem_wdata), 32'h0A1);
    check("c2_ready", 32'(bus.coin_ready), 0);
    send_coin(8'd20);
    check("c3_addr",  32'(bus.mem_waddr), 3);
    check("c3_data",  32'(bus.mem_wdata), 32'h142);
    check("c3_head",  32'(bus.head_addr), 3);
    check("c3_count", 32'(bus.count), 3);
    step();
    check("c3_we_drop", 32'(bus.mem_we), 0);

    // Buy with three nodes: ack at E, sum_start falls at E+7, idle at E+9
    bus.buy_req = 1'b1;
    step();
    bus.buy_req = 1'b0;
    check("buy_ack",    32'(bus.buy_ack), 1);
    check("buy_start",  32'(bus.sum_start), 1);
    check("buy_busy",   32'(bus.busy), 1);
    check("buy_nrej",   32'(bus.buy_reject), 0);
    n = 0;
    while (bus.sum_start && n < 40) begin
      step();
      n++;
      if (n == 1) check("buy_ack_drop", 32'(bus.buy_ack), 0);
    end
    check("start_cycles", 32'(n), 7);
    check("clear_count_stable", 32'(bus.count), 3);
    check("clear_head_stable",  32'(bus.head_addr), 3);
    wait_idle(n);
    check("clear_cycles", 32'(n), 2);
    check("post_count", 32'(bus.count), 0);
    check("post_head",  32'(bus.head_addr), 0);
    check("post_ready", 32'(bus.coin_ready), 1);

    // Buy on an empty list
    bus.buy_req = 1'b1;
    step();
    bus.buy_req = 1'b0;
    check("empty_rej",   32'(bus.buy_reject), 1);
    check("empty_ack",   32'(bus.buy_ack), 0);
    check("empty_start", 32'(bus.sum_start), 0);
    step();
    check("empty_rej_drop", 32'(bus.buy_reject), 0);

    // Coin and buy on the same edge: coin first, buy two edges later
    bus.coin_valid = 1'b1;
    bus.coin_value = 8'd7;
    bus.buy_req    = 1'b1;
    step();
    bus.coin_valid = 1'b0;
    check("tie_we",   32'(bus.mem_we), 1);
    check("tie_addr", 32'(bus.mem_waddr), 1);
    check("tie_data", 32'(bus.mem_wdata), 32'h070);
    check("tie_ack0", 32'(bus.buy_ack), 0);
    step();
    check("tie_ack1", 32'(bus.buy_ack), 0);
    step();
    bus.buy_req = 1'b0;
    check("tie_ack2", 32'(bus.buy_ack), 1);
    wait_idle(n);
    check("tie_count", 32'(bus.count), 0);

    // Fill to 15 nodes
    for (int i = 1; i <= 15; i++) send_coin(8'(i));
    check("fill_addr", 32'(bus.mem_waddr), 15);
    check("fill_data", 32'(bus.mem_wdata), 32'h0FE);
    step();
    check("fill_full",  32'(bus.list_full), 1);
    check("fill_ready", 32'(bus.coin_ready), 0);
    check("fill_count", 32'(bus.count), 15);
    check("fill_head",  32'(bus.head_addr), 15);

    // 16th coin held 10 cycles: no write
    bus.coin_valid = 1'b1;
    bus.coin_value = 8'd99;
    we_seen = 0;
    repeat (10) begin
      step();
      if (bus.mem_we) we_seen++;
    end
    check("full_no_we",    32'(we_seen), 0);
    check("full_count",    32'(bus.count), 15);

    // Buy still legal while full; then reset during WAIT
    bus.buy_req = 1'b1;
    step();
    bus.buy_req    = 1'b0;
    bus.coin_valid = 1'b0;
    check("full_buy_ack", 32'(bus.buy_ack), 1);
    repeat (3) step();
    check("wait_start", 32'(bus.sum_start), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_start", 32'(bus.sum_start), 0);
    check("rst_mid_count", 32'(bus.count), 0);
    check("rst_mid_head",  32'(bus.head_addr), 0);
    check("rst_mid_busy",  32'(bus.busy), 0);
    @(negedge clock);
    reset = 1'b1;
    send_coin(8'd9);
    check("rst_coin_addr", 32'(bus.mem_waddr), 1);
    check("rst_coin_data", 32'(bus.mem_wdata), 32'h090);
    check("rst_coin_head", 32'(bus.head_addr), 1);
    check("rst_coin_cnt",  32'(bus.count), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
